reg_shift_unit: RTL and testbench
=================================

// Module: reg_shift_unit
// PURPOSE
//  Multi-cycle operand-2 shifter for register-specified shifts (amount = Rs[7:0]).
//  The immediate shifter resolves 5-bit amounts in one cycle; this unit covers full 8-bit amounts.
//  Covers LSL/LSR/ASR/ROR with ARM carry-out semantics.
//  Sits beside the immediate shifter in execute and stalls the pipe via ready_o/done_o.
//  Iterates BITS_PER_CYCLE bits per clock.
// PARAMETERS
//  BITS_PER_CYCLE  1  bits shifted per SHIFT-state cycle; legal values 1,2,4,8
// PORTS
//  clk_i     in   1   clock
//  reset_i   in   1   synchronous, active-high reset
//  start_i   in   1   request; accepted only when ready_o=1
//  type_i    in   2   00 LSL, 01 LSR, 10 ASR, 11 ROR
//  amount_i  in   8   shift amount (Rs[7:0])
//  val_i     in   32  operand (Rm)
//  carry_i   in   1   current CPSR.C, passed through when amount=0
//  ready_o   out  1   1 in IDLE
//  done_o    out  1   one-cycle pulse; result_o/carry_o valid
//  result_o  out  32  shifted value; held until next accepted start
//  carry_o   out  1   shifter carry-out; held with result_o
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high on clk_i/reset_i.
//  - Reset values: state=IDLE, ready_o=1, done_o=0, result_o=0, carry_o=0.
//    Reset mid-operation aborts with no done_o.
//  - FSM states:
//    - IDLE --start_i--> SHIFT. Captures type, amount, val, carry_i; ready_o=0 from the next cycle.
//    - SHIFT: each cycle shifts by k=min(rem,BITS_PER_CYCLE) and decrements rem. At rem=0 go to DONE.
//    - DONE: done_o=1 for exactly one cycle, then IDLE.
//  - Step count n:
//    - LSL/LSR/ASR: n=min(amount,32).
//    - ROR: n=amount[4:0].
//    - n=0: SHIFT lasts one cycle with no data change.
//  - Latency: start accept -> done_o = 2 + ceil(n/BITS_PER_CYCLE) cycles, with n=0 counting as 1 step.
//  - Carry per k-bit step:
//    - LSL: C=v[32-k].
//    - LSR/ASR: C=v[k-1].
//    - ROR: C=result[31] after the rotate.
//    - ASR fills with the sign bit; LSR/LSL fill with 0.
//  - Boundary rules, applied when entering DONE:
//    - amount=0 (any type): result=val, carry=carry_i.
//    - LSL 32: result=0, C=val[0]. LSL >32: result=0, C=0.
//    - LSR 32: result=0, C=val[31]. LSR >32: result=0, C=0.
//    - ASR >=32: result={32{val[31]}}, C=val[31].
//    - ROR with amount!=0 and amount[4:0]=0: result=val, C=val[31].
//  - start_i while ready_o=0 is ignored (no queueing).
//  - start_i in the DONE cycle is ignored.
//  - result_o/carry_o change only on entry to DONE.
// CONFIGURATION
//  - SHIFT_FASTPATH_EN defined: amount=0, LSL/LSR/ASR with amount>=32, and ROR with amount[4:0]=0
//    go IDLE->DONE directly, skipping SHIFT; latency 2 cycles.
//  - SHIFT_FASTPATH_EN undefined: every request passes through SHIFT (latency formula above).
//  - Results are identical in both builds.
// STRUCTURE
//  - cpu_pkg:
//    - shift-type constants SHIFT_LSL=2'b00, SHIFT_LSR=2'b01, SHIFT_ASR=2'b10, SHIFT_ROR=2'b11.
//    - FSM state encodings ST_IDLE/ST_SHIFT/ST_DONE.
//  - Sub-module shift_step: combinational k-bit (k<=8) shift of a 32-bit value with carry-out.
//    Instanced once; the FSM/counters live in reg_shift_unit.
// TESTING
//  1. LSL val=0x8000_0001, amt=1 -> result 0x0000_0002, C=1; done_o 3 cycles after accept (BPC=1).
//  2. ASR val=0x8000_0000, amt=40 -> result 0xFFFF_FFFF, C=1.
//     LSR same val, amt=32 -> 0, C=1.
//     LSL amt=33 -> 0, C=0.
//  3. ROR val=0x0000_00F1, amt=4 -> 0x1000_000F, C=0.
//     ROR amt=32 -> 0x0000_00F1, C=0.
//  4. amt=0, carry_i=1, any type -> result=val, C=1.
//     Check done_o latency in both SHIFT_FASTPATH_EN builds.
//  5. Second start_i pulsed while busy -> ignored; exactly one done_o; result from first request only.
//  6. reset_i asserted mid-SHIFT -> next cycle ready_o=1, result_o=0, done_o never pulses.
//     Repeat 1-3 with BITS_PER_CYCLE=4 and 8, random compare vs reference model.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shift-type codes, shifter FSM states and the boundary-amount rules for register shifts
package cpu_pkg;
  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  // Amounts whose result does not come from ordinary iteration: zero, >=32 linear, ROR by a multiple of 32
  function automatic logic bnd_hit(input logic [1:0] t, input logic [7:0] a);
    return a == 8'd0 || (t == SHIFT_ROR ? a[4:0] == 5'd0 : a > 8'd31);
  endfunction
  // {carry, result} for a boundary amount
  function automatic logic [32:0] bnd_val(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v, input logic c);
    return a == 8'd0 ? {c, v} :
           t == SHIFT_ROR ? {v[31], v} :
           t == SHIFT_ASR ? {33{v[31]}} :
           {a == 8'd32 && (t == SHIFT_LSL ? v[0] : v[31]), 32'd0};
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational k-bit (k<=8) LSL/LSR/ASR/ROR of a 32-bit value with carry-out
// Ports: v_i operand, type_i shift type, k_i step size, r_o shifted value, c_o carry-out of this step.
module shift_step
  import cpu_pkg::*;
(
  input  logic [31:0] v_i,
  input  logic [1:0]  type_i,
  input  logic [5:0]  k_i,
  output logic [31:0] r_o,
  output logic        c_o
);
  assign r_o = type_i == SHIFT_LSL ? v_i << k_i :
               type_i == SHIFT_LSR ? v_i >> k_i :
               type_i == SHIFT_ASR ? 32'($signed(v_i) >>> k_i) :
               (v_i >> k_i) | (v_i << (6'd32 - k_i));
  assign c_o = type_i == SHIFT_LSL ? v_i[5'(6'd32 - k_i)] :
               type_i == SHIFT_ROR ? r_o[31] :
               v_i[5'(k_i - 6'd1)];
endmodule

// File: rtl/reg_shift_unit.sv
// reg_shift_unit: multi-cycle LSL/LSR/ASR/ROR by an 8-bit register amount with ARM carry-out
// Ports: clk_i, reset_i (sync, active-high); start_i/type_i/amount_i/val_i/carry_i request, taken when ready_o;
// ready_o high in IDLE; done_o one-cycle pulse; result_o/carry_o hold until the next completion.
// Build option SHIFT_FASTPATH_EN: boundary amounts go straight to DONE (two-cycle latency).
module reg_shift_unit
  import cpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  type_i,
  input  logic [7:0]  amount_i,
  input  logic [31:0] val_i,
  input  logic        carry_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        carry_o
);
  localparam logic [5:0] BPC = 6'(BITS_PER_CYCLE);
  state_t state, state_n;
  logic [1:0] typ;
  logic [7:0] amt;
  logic [31:0] val_s, v, step_r;
  logic cin, step_c, fast, accept, last;
  logic [5:0] rem, k, n_i;
  assign k = rem < BPC ? rem : BPC;
  assign n_i = type_i == SHIFT_ROR ? {1'b0, amount_i[4:0]} : amount_i > 8'd31 ? 6'd32 : amount_i[5:0];
  assign accept = state == ST_IDLE && start_i;
  assign last = state == ST_SHIFT && rem == k;
  assign ready_o = state == ST_IDLE;
  assign done_o = state == ST_DONE;
`ifdef SHIFT_FASTPATH_EN
  assign fast = bnd_hit(type_i, amount_i);
`else
  assign fast = 1'b0;
`endif
  shift_step u_step (
    .v_i   (v),
    .type_i(typ),
    .k_i   (k),
    .r_o   (step_r),
    .c_o   (step_c)
  );
  always_comb begin
    state_n = state;
    if (accept) state_n = fast ? ST_DONE : ST_SHIFT;
    else if (last) state_n = ST_DONE;
    else if (state == ST_DONE) state_n = ST_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ST_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      result_o <= 32'd0;
      carry_o <= 1'b0;
    end else begin
      if (accept) begin
        typ <= type_i;
        amt <= amount_i;
        val_s <= val_i;
        cin <= carry_i;
        v <= val_i;
        rem <= n_i;
        if (fast) {carry_o, result_o} <= bnd_val(type_i, amount_i, val_i, carry_i);
      end
      if (state == ST_SHIFT) begin
        v <= step_r;
        rem <= rem - k;
        if (last) {carry_o, result_o} <= bnd_hit(typ, amt) ? bnd_val(typ, amt, val_s, cin) : {step_c, step_r};
      end
    end
  end
endmodule

// File: tb/tb_reg_shift_unit.sv
// tb_reg_shift_unit: scoreboard bench driving BITS_PER_CYCLE=1/4/8 instances in lockstep against a reference model
module tb_reg_shift_unit;
  localparam int BPCS[3] = '{1, 4, 8};
  typedef struct {
    logic [31:0] r;
    logic c;
    int lat;
    int acyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_i, start_i, carry_i;
  logic [1:0] type_i;
  logic [7:0] amount_i;
  logic [31:0] val_i;
  logic rdy[3], dn[3], cout[3];
  logic [31:0] res[3];
  exp_t q[3][$];
  int dcnt[3];
  int n_chk = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v, input logic c);
    int s;
    logic [31:0] r;
    s = int'(a);
    if (s == 0) return {c, v};
    if (t == 2'b00) return s < 32 ? {v[32-s], v << s} : {s == 32 && v[0], 32'd0};
    if (t == 2'b01) return s < 32 ? {v[s-1], v >> s} : {s == 32 && v[31], 32'd0};
    if (t == 2'b10) return s < 32 ? {v[s-1], 32'($signed(v) >>> s)} : {33{v[31]}};
    s = s % 32;
    if (s == 0) return {v[31], v};
    r = (v >> s) | (v << (32 - s));
    return {r[31], r};
  endfunction
  function automatic int exp_lat(input logic [1:0] t, input logic [7:0] a, input int bpc);
    int n;
    n = t == 2'b11 ? int'(a) % 32 : (int'(a) > 32 ? 32 : int'(a));
`ifdef SHIFT_FASTPATH_EN
    if (a == 8'd0 || (t == 2'b11 ? n == 0 : int'(a) >= 32)) return 2;
`endif
    return 2 + (n == 0 ? 1 : (n + bpc - 1) / bpc);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    exp_t e;
    reg_shift_unit #(.BITS_PER_CYCLE(BPCS[g])) u_dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .start_i (start_i),
      .type_i  (type_i),
      .amount_i(amount_i),
      .val_i   (val_i),
      .carry_i (carry_i),
      .ready_o (rdy[g]),
      .done_o  (dn[g]),
      .result_o(res[g]),
      .carry_o (cout[g])
    );
    always @(negedge clk) if (dn[g]) begin
      dcnt[g]++;
      if (q[g].size() == 0) check($sformatf("spurious_done_b%0d", BPCS[g]), 1, 0);
      else begin
        e = q[g].pop_front();
        check($sformatf("result_b%0d", BPCS[g]), 64'(res[g]), 64'(e.r));
        check($sformatf("carry_b%0d", BPCS[g]), 64'(cout[g]), 64'(e.c));
        check($sformatf("latency_b%0d", BPCS[g]), 64'(cyc - e.acyc + 2), 64'(e.lat));
      end
    end
  end
  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy[0] && rdy[1] && rdy[2] && q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) return;
    end
    check("idle_timeout", 0, 1);
  endtask
  task automatic drive(input logic [1:0] t, input logic [7:0] a, input logic [31:0] v, input logic c);
    logic [32:0] m;
    wait_idle();
    type_i = t;
    amount_i = a;
    val_i = v;
    carry_i = c;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    m = model(t, a, v, c);
    for (int g = 0; g < 3; g++) q[g].push_back('{r: m[31:0], c: m[32], lat: exp_lat(t, a, BPCS[g]), acyc: cyc});
  endtask
  initial begin
    logic [7:0] amts[10];
    int d0[3];
    amts = '{8'd0, 8'd1, 8'd7, 8'd8, 8'd31, 8'd32, 8'd33, 8'd40, 8'd64, 8'd255};
    reset_i = 1'b1;
    start_i = 1'b0;
    type_i = 2'b00;
    amount_i = 8'd0;
    val_i = 32'd0;
    carry_i = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_ready", 64'(rdy[g]), 1);
      check("rst_done", 64'(dn[g]), 0);
      check("rst_result", 64'(res[g]), 0);
      check("rst_carry", 64'(cout[g]), 0);
    end
    reset_i = 1'b0;
    drive(2'b00, 8'd1, 32'h8000_0001, 1'b0);
    check("busy_ready", 64'(rdy[0]), 0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_result", 64'(res[0]), 64'h2);
    check("hold_carry", 64'(cout[0]), 1);
    drive(2'b10, 8'd40, 32'h8000_0000, 1'b0);
    drive(2'b01, 8'd32, 32'h8000_0000, 1'b0);
    drive(2'b00, 8'd33, 32'h8000_0000, 1'b1);
    drive(2'b11, 8'd4, 32'h0000_00F1, 1'b1);
    drive(2'b11, 8'd32, 32'h0000_00F1, 1'b1);
    for (int t = 0; t < 4; t++) drive(2'(t), 8'd0, 32'hA5C3_0F96, 1'b1);
    drive(2'b00, 8'd8, 32'h1234_5678, 1'b0);
    d0 = dcnt;
    @(negedge clk);
    type_i = 2'b11;
    amount_i = 8'd3;
    val_i = 32'hDEAD_BEEF;
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    wait_idle();
    for (int g = 0; g < 3; g++) check("one_done", 64'(dcnt[g] - d0[g]), 1);
    for (int i = 0; i < 60; i++)
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1 ? amts[$urandom_range(0, 9)] : 8'($urandom),
            $urandom, 1'($urandom_range(0, 1)));
    drive(2'b00, 8'd30, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) q[g].delete();
    d0 = dcnt;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("abort_ready", 64'(rdy[g]), 1);
      check("abort_result", 64'(res[g]), 0);
      check("abort_carry", 64'(cout[g]), 0);
    end
    repeat (40) @(negedge clk);
    for (int g = 0; g < 3; g++) check("abort_no_done", 64'(dcnt[g] - d0[g]), 0);
    drive(2'b01, 8'd5, 32'h8000_0010, 1'b0);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
